// File: rtl/instr_executor.sv
// -----------------------------------------------------------------------------
// instr_register_pkg / instr_executor
//
// Purpose:
//   Shared types for the instruction register path, plus the executor that
//   walks an inclusive address range of instr_register. It executes each
//   instruction on sign-extended operands and presents one result per
//   instruction on a valid/ready channel.
//
// Ports (instr_executor):
//   clk              - single clock, all state updates on rising edge
//   reset            - asynchronous, active-high; aborts any run immediately
//   start            - one-cycle run request, honoured only while idle
//   first_addr       - first address of the range, sampled with start
//   last_addr        - last address of the range (inclusive), sampled with start
//   read_pointer     - address presented to instr_register
//   instruction_word - combinational read data from instr_register
//   res_valid        - result and res_* fields are valid
//   res_ready        - downstream accepts on res_valid && res_ready
//   result           - signed result, RES_W bits
//   res_opcode       - opcode that produced result
//   res_addr         - address the instruction was read from
//   res_div0         - DIV/MOD attempted with operand_b == 0
//   busy             - high whenever a run is in progress
//   done             - one-cycle pulse after the last result is accepted
// -----------------------------------------------------------------------------

package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic        [4:0]  address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

endpackage

module instr_executor
  import instr_register_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int RES_W  = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       first_addr,
  input  logic [ADDR_W-1:0]       last_addr,
  output logic [ADDR_W-1:0]       read_pointer,
  input  instruction_t            instruction_word,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [RES_W-1:0] result,
  output opcode_t                 res_opcode,
  output logic [ADDR_W-1:0]       res_addr,
  output logic                    res_div0,
  output logic                    busy,
  output logic                    done
);

  localparam int OP_W = $bits(operand_t);

  // remaining needs one extra bit so a full-depth run (2**ADDR_W entries) fits
  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_OUT,
    ST_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_W:0]         remaining;
  instruction_t            iw_q;

  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  logic signed [RES_W-1:0] exec_result;
  logic                    exec_div0;

  // Execution unit. Works only on the captured instruction so that register
  // file writes after FETCH cannot disturb the result being produced.
  // Operands are sign-extended first, so MULT yields the full product and
  // DIV/MOD use the language's truncate-toward-zero / sign-of-dividend rules.
  always_comb begin
    a_ext       = {{(RES_W-OP_W){iw_q.op_a[OP_W-1]}}, iw_q.op_a};
    b_ext       = {{(RES_W-OP_W){iw_q.op_b[OP_W-1]}}, iw_q.op_b};
    exec_result = '0;
    exec_div0   = 1'b0;
    case (iw_q.opc)
      ZERO:  exec_result = '0;
      PASSA: exec_result = a_ext;
      PASSB: exec_result = b_ext;
      ADD:   exec_result = a_ext + b_ext;
      SUB:   exec_result = a_ext - b_ext;
      MULT:  exec_result = a_ext * b_ext;
      DIV: begin
        if (b_ext == '0) exec_div0 = 1'b1;
        else             exec_result = a_ext / b_ext;
      end
      MOD: begin
        if (b_ext == '0) exec_div0 = 1'b1;
        else             exec_result = a_ext % b_ext;
      end
      default: exec_result = '0;
    endcase
  end

  // Control FSM with all outputs registered. busy rises on leaving IDLE and
  // falls on leaving DONE; done is set only for the single DONE cycle.
  // In OUT, res_valid is always high, so res_ready alone is the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      read_pointer <= '0;
      remaining    <= '0;
      iw_q         <= '0;
      result       <= '0;
      res_opcode   <= ZERO;
      res_addr     <= '0;
      res_div0     <= 1'b0;
      res_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            read_pointer <= first_addr;
            remaining    <= {1'b0, ADDR_W'(last_addr - first_addr)} + REM_ONE;
            busy         <= 1'b1;
            state        <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          iw_q  <= instruction_word;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          result     <= exec_result;
          res_opcode <= iw_q.opc;
          res_addr   <= read_pointer;
          res_div0   <= exec_div0;
          res_valid  <= 1'b1;
          state      <= ST_OUT;
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            remaining <= remaining - REM_ONE;
            if (remaining == REM_ONE) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              read_pointer <= read_pointer + PTR_ONE;
              state        <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
